// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - requester/bank bus between writeback ports and reg_write_arbiter
interface reg_write_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int WIDTH  = 8,
    parameter int NREG   = 4,
    parameter int ADDR_W = 2
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*WIDTH-1:0]  req_data;
    logic [NREQ-1:0]        req_lock;
    logic                   bank_stall;
    logic [NREG-1:0]        reg_en;
    logic [WIDTH-1:0]       reg_data;
    logic [ID_W-1:0]        grant_id;
    logic                   wr_valid;
    logic                   addr_err;

    modport master (
        output req_valid, req_addr, req_data, req_lock, bank_stall,
        input  req_ready, reg_en, reg_data, grant_id, wr_valid, addr_err
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_lock, bank_stall,
        output req_ready, reg_en, reg_data, grant_id, wr_valid, addr_err
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin write arbiter for an enable-gated register bank
// Optional burst lock when ARB_LOCK_EN is defined.
module reg_write_arbiter #(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int NREG     = 4,
    parameter int ADDR_W   = 2,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    reg_write_arbiter_if.slave bus
);
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   ptr_d;
    logic [ID_W-1:0]   win;
    logic [ID_W-1:0]   win_nxt;
    logic [ID_W-1:0]   idx;
    logic              found;
    logic              accept;
    logic [ADDR_W-1:0] w_addr;
    logic [WIDTH-1:0]  w_data;
    logic              addr_ok;

`ifdef ARB_LOCK_EN
    typedef enum logic {RR, LOCKED} state_t;
    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       w_lock;
`endif

    // Search starts at rr_ptr and wraps; the first valid requester wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ID_W'((int'(rr_ptr) + i) % NREQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign accept        = found & ~bus.bank_stall & ~reset;
    assign bus.req_ready = accept ? (NREQ'(1) << win) : '0;
    assign win_nxt       = ID_W'((int'(win) + 1) % NREQ);
    assign w_addr        = bus.req_addr[win*ADDR_W +: ADDR_W];
    assign w_data        = bus.req_data[win*WIDTH +: WIDTH];
    assign addr_ok       = int'(w_addr) < NREG;
`ifdef ARB_LOCK_EN
    assign w_lock        = bus.req_lock[win];
`endif

    always_comb begin
        ptr_d = rr_ptr;
`ifdef ARB_LOCK_EN
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.bank_stall) begin
            case (state_q)
                RR: begin
                    if (accept && w_lock) begin
                        state_d = LOCKED;
                        cnt_d   = cnt_q + 3'd1;
                        ptr_d   = win;
                    end else if (accept) begin
                        ptr_d = win_nxt;
                    end
                end
                LOCKED: begin
                    // rr_ptr holds the owner, so the owner always wins while valid.
                    if (accept && win == rr_ptr && w_lock) begin
                        if (int'(cnt_q) + 1 >= LOCK_MAX) begin
                            state_d = RR;
                            cnt_d   = '0;
                            ptr_d   = win_nxt;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                            ptr_d = win;
                        end
                    end else begin
                        state_d = RR;
                        cnt_d   = '0;
                        if (accept) ptr_d = win_nxt;
                    end
                end
                default: begin
                    state_d = RR;
                    cnt_d   = '0;
                end
            endcase
        end
`else
        if (accept) ptr_d = win_nxt;
`endif
    end

`ifdef ARB_LOCK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`endif

    // Stall freezes the whole output stage so the bank sees the same write repeated.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr       <= '0;
            bus.reg_en   <= '0;
            bus.reg_data <= '0;
            bus.grant_id <= '0;
            bus.wr_valid <= 1'b0;
            bus.addr_err <= 1'b0;
        end else if (!bus.bank_stall) begin
            rr_ptr <= ptr_d;
            if (accept) begin
                bus.grant_id <= win;
                bus.reg_data <= w_data;
                if (addr_ok) begin
                    bus.reg_en   <= NREG'(1) << w_addr;
                    bus.wr_valid <= 1'b1;
                    bus.addr_err <= 1'b0;
                end else begin
                    bus.reg_en   <= '0;
                    bus.wr_valid <= 1'b0;
                    bus.addr_err <= 1'b1;
                end
            end else begin
                bus.reg_en   <= '0;
                bus.wr_valid <= 1'b0;
                bus.addr_err <= 1'b0;
            end
        end
    end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Round-robin arbiter and sequencer that shares a bank of NREG enable-gated registers among NREQ write requesters.
- Each requester presents a valid/ready write request carrying a register address and data.
- The block picks one winner per cycle and drives a one-hot register enable plus the data bus for one clock, registered.
- Sits between execution-unit writeback ports and the register bank: register instances take en=reg_en[i] and data=reg_data.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, register data width.
- NREG, 4, number of registers in the bank.
- ADDR_W, 2, register address width; NREG <= 2**ADDR_W.
- LOCK_MAX, 4, maximum consecutive locked grants (used only with ARB_LOCK_EN).

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- req_valid, input, NREQ: request valid, one bit per requester.
- req_ready, output, NREQ: request accepted this cycle; combinational, one-hot or zero.
- req_addr, input, NREQ*ADDR_W: packed register addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- req_data, input, NREQ*WIDTH: packed write data; requester i occupies [i*WIDTH +: WIDTH].
- req_lock, input, NREQ: burst-lock hint; ignored unless ARB_LOCK_EN is defined.
- bank_stall, input, 1: downstream hold. While high, nothing is accepted and the output stage holds.
- reg_en, output, NREG: registered one-hot write enable.
- reg_data, output, WIDTH: registered write data.
- grant_id, output, clog2(NREQ): registered index of the requester whose write is on reg_en/reg_data.
- wr_valid, output, 1: registered; high when reg_en is nonzero.
- addr_err, output, 1: registered one-cycle pulse when an accepted request carried addr >= NREG.

Behaviour:
- Reset (async, while reset=1):
  - reg_en=0, reg_data=0, grant_id=0, wr_valid=0, addr_err=0.
  - Round-robin pointer rr_ptr=0.
  - req_ready=0 combinationally while reset is high.
- Arbitration, combinational, each cycle with bank_stall=0:
  - Search req_valid starting at index rr_ptr, ascending, wrapping NREQ-1 -> 0.
  - The first set bit is the winner w; req_ready[w]=1 and all other ready bits are 0.
  - A handshake completes when req_valid[w] and req_ready[w] are both high.
- Latency:
  - An accepted request drives reg_en[addr]=1, reg_data=data and grant_id=w on the next cycle, for exactly one cycle.
  - Throughput is one write per cycle.
  - With no acceptance in a cycle, reg_en=0 and wr_valid=0 on the next cycle; reg_data and grant_id keep their last values.
- Pointer update on acceptance: rr_ptr <= (w+1) mod NREQ. Without acceptance, rr_ptr holds.
- Stall:
  - While bank_stall=1: req_ready=0, and reg_en, reg_data, grant_id, wr_valid and addr_err all hold their current values. rr_ptr holds.
  - A write already on reg_en therefore stays asserted; repeating it is idempotent.
  - When bank_stall deasserts, normal operation resumes in that same cycle.
- Out-of-range address (addr >= NREG):
  - The request is still accepted, so the requester is not deadlocked.
  - Next cycle: reg_en=0, wr_valid=0, addr_err=1.
  - rr_ptr advances normally.
- Simultaneous requests for the same register address: serialized by arbitration order; the last write in time wins.
- Reset mid-operation: the in-flight write is dropped, reg_en clears immediately (async), and arbitration restarts at requester 0.
- State machine, with ARB_LOCK_EN only: RR (normal) and LOCKED (see Optional Feature).

Optional Feature:
Macro ARB_LOCK_EN.
- Defined:
  - If the winner w has req_lock[w]=1 at acceptance, rr_ptr <= w (not w+1), the FSM enters LOCKED, and the 3-bit lock_cnt is incremented.
  - In LOCKED, w keeps first priority.
  - LOCKED exits to RR when any of these occurs:
    - an acceptance with req_lock[w]=0;
    - w is not valid;
    - lock_cnt reaches LOCK_MAX.
  - On a LOCK_MAX exit, rr_ptr <= w+1 (forced rotation) and lock_cnt <= 0.
  - Stall holds both FSM state and lock_cnt.
- Not defined: req_lock is ignored, there is no FSM and no lock_cnt, and arbitration is pure round-robin.

Test Plan:
- Reset release, all four req_valid=1, all req_addr=1, no stall -> req_ready one-hot in sequence 0,1,2,3,0; grant_id one cycle later 0,1,2,3; reg_en=4'b0010 every cycle.
- Requester 2 only: valid, addr=3, data=8'hA5 for one cycle -> next cycle reg_en=4'b1000, reg_data=8'hA5, grant_id=2, wr_valid=1; the following cycle reg_en=0.
- Requester 1 accepted (addr=0, data=8'h3C), then bank_stall=1 for 3 cycles with requesters 0 and 3 valid -> reg_en=4'b0001 and reg_data=8'h3C hold for all 3 cycles, req_ready=0 throughout; after release requester 3 is granted first (rr_ptr=2).
- Requester 0 issues addr=3 with NREG=3 -> req_ready[0]=1; next cycle addr_err=1, reg_en=0, wr_valid=0.
- Assert reset mid-stream while reg_en=4'b0100 -> reg_en=0 asynchronously; after release with requesters 1 and 3 valid, requester 1 is granted first.
- ARB_LOCK_EN, requesters 0 and 1 valid, req_lock[0]=1 held -> requester 0 granted 4 consecutive times, then requester 1; without the macro, 0,1,0,1.
